// File: rtl/da_slice_accumulator_if.sv
// Bit-slice, coefficient-load and result bundle for the DA accumulator.
// Producer side drives slices and coefficient writes; consumer returns y.
interface da_slice_accumulator_if #(
   parameter int COEF_W = 16,
   parameter int ACC_W  = 38
);
   logic                     start;
   logic                     in_valid;
   logic [7:0]               A7;
   logic [7:0]               A6;
   logic [7:0]               A5;
   logic [7:0]               A4;
   logic [7:0]               A3;
   logic [7:0]               A2;
   logic [7:0]               A1;
   logic [7:0]               A0;
   logic                     coef_we;
   logic [5:0]               coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     coef_rdy;
   logic                     busy;
   logic signed [ACC_W-1:0]  y;
   logic                     y_valid;
   logic                     overrun;

   modport master (
      output start, in_valid,
      output A7, A6, A5, A4, A3, A2, A1, A0,
      output coef_we, coef_addr, coef_data,
      input  coef_rdy, busy, y, y_valid, overrun
   );

   modport slave (
      input  start, in_valid,
      input  A7, A6, A5, A4, A3, A2, A1, A0,
      input  coef_we, coef_addr, coef_data,
      output coef_rdy, busy, y, y_valid, overrun
   );
endinterface

// File: rtl/da_slice_accumulator.sv
// Distributed-arithmetic FIR back end: per-slice coefficient sum,
// then LSB-first shift-accumulate of DATA_W slices into one sample.
module da_slice_accumulator #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 64,
   parameter int ACC_W  = 38
) (
   input logic                  clk,
   input logic                  resetn,
   da_slice_accumulator_if.slave bus
);

   localparam int SW = $clog2(DATA_W);
   localparam int AW = $clog2(NTAPS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [SW-1:0]           cnt_q;
   logic [SW-1:0]           cnt_d;

   logic                    cap;
   logic                    abort;
   logic [SW-1:0]           cap_idx;
   logic                    cap_last;

   logic signed [COEF_W-1:0] coef_q [NTAPS];
   logic [NTAPS-1:0]        taps;
   logic signed [ACC_W-1:0] psum;

   logic                    s1_vld;
   logic signed [ACC_W-1:0] s1_p;
   logic [SW-1:0]           s1_idx;
   logic                    s1_last;

   logic signed [ACC_W-1:0] acc_q;
   logic                    s2_done;

   logic                    busy_q;
   logic                    overrun_q;
   logic signed [ACC_W-1:0] y_q;
   logic                    y_valid_q;

   // Tap n = 8k+j lives on A_k[j]
   assign taps = {bus.A7, bus.A6, bus.A5, bus.A4,
                  bus.A3, bus.A2, bus.A1, bus.A0};

   assign bus.coef_rdy = ~busy_q;
   assign bus.busy     = busy_q;
   assign bus.y        = y_q;
   assign bus.y_valid  = y_valid_q;
   assign bus.overrun  = overrun_q;

   // Sum of coefficients whose tap bit is set in this slice
   always_comb begin
      psum = '0;
      for (int n = 0; n < NTAPS; n++) begin
         if (taps[n]) begin
            psum = psum +
               {{(ACC_W-COEF_W){coef_q[n][COEF_W-1]}}, coef_q[n]};
         end
      end
   end

   // Frame sequencing: slice capture, stall, abort on early start
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap     = 1'b0;
      abort   = 1'b0;
      cap_idx = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               cnt_d   = SW'(1);
               cap     = 1'b1;
               cap_idx = '0;
            end
         end
         RUN: begin
            if (bus.start) begin
               abort   = 1'b1;
               cnt_d   = SW'(1);
               cap     = 1'b1;
               cap_idx = '0;
            end else if (bus.in_valid) begin
               cap = 1'b1;
               if (cnt_q == SW'(DATA_W-1)) begin
                  state_d = DRAIN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (bus.start) begin
               abort   = 1'b1;
               state_d = RUN;
               cnt_d   = SW'(1);
               cap     = 1'b1;
               cap_idx = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      cap_last = cap && (cap_idx == SW'(DATA_W-1));
   end

   // FSM state and slice counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Coefficient bank; writes only land while idle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int n = 0; n < NTAPS; n++) begin
            coef_q[n] <= '0;
         end
      end else if (bus.coef_we && !busy_q) begin
         coef_q[bus.coef_addr[AW-1:0]] <= bus.coef_data;
      end
   end

   // Stage 1: register partial sum with its slice position
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_vld  <= 1'b0;
         s1_p    <= '0;
         s1_idx  <= '0;
         s1_last <= 1'b0;
      end else begin
         s1_vld <= cap;
         if (cap) begin
            s1_p    <= psum;
            s1_idx  <= cap_idx;
            s1_last <= cap_last;
         end
      end
   end

   // Stage 2: weighted accumulate; MSB slice carries negative weight
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_q   <= '0;
         s2_done <= 1'b0;
      end else if (abort) begin
         s2_done <= 1'b0;
      end else if (s1_vld) begin
         if (s1_idx == '0) begin
            acc_q <= s1_p;
         end else if (s1_last) begin
            acc_q <= acc_q - (s1_p <<< (DATA_W-1));
         end else begin
            acc_q <= acc_q + (s1_p <<< s1_idx);
         end
         s2_done <= s1_last;
      end else begin
         s2_done <= 1'b0;
      end
   end

   // Result register and one-cycle valid pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         y_valid_q <= s2_done;
         if (s2_done) begin
            y_q <= acc_q;
         end
      end
   end

   // Busy spans slice-0 capture up to the result edge; overrun is sticky
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (cap && (cap_idx == '0)) begin
            busy_q <= 1'b1;
         end else if (s2_done) begin
            busy_q <= 1'b0;
         end
         if (abort) begin
            overrun_q <= 1'b1;
         end
      end
   end

endmodule
